// File: rtl/oq_regs_update_arb.sv
// Arbitrated read-modify-write sequencer for the per-queue occupancy register
// file ({num_pkts_in_q, num_words_left}) shared by store, remove and host.
module oq_regs_update_arb #(
  parameter int unsigned NUM_OUTPUT_QUEUES = 8,
  parameter int unsigned NUM_OQ_WIDTH      = 3,
  parameter int unsigned SRAM_ADDR_WIDTH   = 19,
  parameter int unsigned PKTS_IN_RAM_WIDTH = 16,
  parameter int unsigned PKT_WORDS_WIDTH   = 8,
  parameter int unsigned REG_MAX_WAIT      = 4
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         dst_req,
  input  logic [NUM_OQ_WIDTH-1:0]                      dst_oq,
  input  logic [PKT_WORDS_WIDTH-1:0]                   dst_words,
  output logic                                         dst_ack,
  input  logic                                         src_req,
  input  logic [NUM_OQ_WIDTH-1:0]                      src_oq,
  input  logic [PKT_WORDS_WIDTH-1:0]                   src_words,
  output logic                                         src_ack,
  input  logic                                         reg_req,
  input  logic                                         reg_wr,
  input  logic [NUM_OQ_WIDTH:0]                        reg_addr,
  input  logic [SRAM_ADDR_WIDTH-1:0]                   reg_wr_data,
  output logic                                         reg_ack,
  output logic [SRAM_ADDR_WIDTH-1:0]                   reg_rd_data,
  output logic                                         rf_rd_en,
  output logic [NUM_OQ_WIDTH-1:0]                      rf_addr,
  input  logic [PKTS_IN_RAM_WIDTH+SRAM_ADDR_WIDTH-1:0] rf_rd_data,
  output logic                                         rf_wr_en,
  output logic [PKTS_IN_RAM_WIDTH+SRAM_ADDR_WIDTH-1:0] rf_wr_data,
  output logic                                         dst_update,
  output logic                                         src_update,
  output logic                                         dst_done,
  output logic                                         src_done,
  output logic                                         err
);

  localparam int unsigned RF_W   = PKTS_IN_RAM_WIDTH + SRAM_ADDR_WIDTH;
  localparam int unsigned SUM_W  = SRAM_ADDR_WIDTH + 1;
  localparam int unsigned WAIT_W = $clog2(REG_MAX_WAIT + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_MOD  = 2'd2;
  localparam logic [1:0] ST_WR   = 2'd3;

  localparam logic [1:0] OP_DST = 2'd0;
  localparam logic [1:0] OP_SRC = 2'd1;
  localparam logic [1:0] OP_REG = 2'd2;

  // Queue index must be able to address every queue
  if (NUM_OUTPUT_QUEUES > (1 << NUM_OQ_WIDTH)) begin : g_cfg_check
    $error("NUM_OQ_WIDTH too small for NUM_OUTPUT_QUEUES");
  end

  logic [1:0]                   state_q, state_d;
  logic [1:0]                   op_q, op_d;
  logic                         rr_q, rr_d;
  logic [WAIT_W-1:0]            wait_q, wait_d;
  logic [NUM_OQ_WIDTH-1:0]      oq_q, oq_d;
  logic [PKT_WORDS_WIDTH-1:0]   words_q, words_d;
  logic                         reg_wr_q, reg_wr_d;
  logic                         field_q, field_d;
  logic [SRAM_ADDR_WIDTH-1:0]   wdata_q, wdata_d;

  logic                         dst_ack_q, dst_ack_d;
  logic                         src_ack_q, src_ack_d;
  logic                         reg_ack_q, reg_ack_d;
  logic [SRAM_ADDR_WIDTH-1:0]   reg_rd_data_q, reg_rd_data_d;
  logic                         rf_rd_en_q, rf_rd_en_d;
  logic                         rf_wr_en_q, rf_wr_en_d;
  logic [RF_W-1:0]              rf_wr_data_q, rf_wr_data_d;
  logic                         dst_done_q, dst_done_d;
  logic                         src_done_q, src_done_d;
  logic                         err_q, err_d;

  logic                         arb_en, reg_req_eff;
  logic                         gnt_dst, gnt_src, gnt_reg;
  logic [PKTS_IN_RAM_WIDTH-1:0] rd_pkts, new_pkts;
  logic [SRAM_ADDR_WIDTH-1:0]   rd_words, new_words, words_ext;
  logic [SUM_W-1:0]             words_sum;
  logic                         sat;

  // Arbitration, next state, held request fields and RMW arithmetic
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    rr_d          = rr_q;
    wait_d        = wait_q;
    oq_d          = oq_q;
    words_d       = words_q;
    reg_wr_d      = reg_wr_q;
    field_d       = field_q;
    wdata_d       = wdata_q;
    dst_ack_d     = 1'b0;
    src_ack_d     = 1'b0;
    reg_ack_d     = 1'b0;
    reg_rd_data_d = '0;
    rf_rd_en_d    = 1'b0;
    rf_wr_en_d    = 1'b0;
    rf_wr_data_d  = rf_wr_data_q;
    dst_done_d    = 1'b0;
    src_done_d    = 1'b0;
    err_d         = 1'b0;
    gnt_dst       = 1'b0;
    gnt_src       = 1'b0;
    gnt_reg       = 1'b0;
    sat           = 1'b0;

    // A reg requester is still holding reg_req in the cycle its ack is out
    arb_en      = (state_q == ST_IDLE) || (state_q == ST_WR);
    reg_req_eff = reg_req && !((state_q == ST_WR) && (op_q == OP_REG));

    rd_pkts   = rf_rd_data[RF_W-1:SRAM_ADDR_WIDTH];
    rd_words  = rf_rd_data[SRAM_ADDR_WIDTH-1:0];
    words_ext = SRAM_ADDR_WIDTH'(words_q);
    words_sum = SUM_W'(rd_words) + SUM_W'(words_q);
    new_pkts  = rd_pkts;
    new_words = rd_words;

    if (arb_en) begin
      if (reg_req_eff && (wait_q == WAIT_W'(REG_MAX_WAIT))) begin
        gnt_reg = 1'b1;
      end else if (dst_req && src_req) begin
        gnt_dst = !rr_q;
        gnt_src = rr_q;
      end else if (dst_req) begin
        gnt_dst = 1'b1;
      end else if (src_req) begin
        gnt_src = 1'b1;
      end else if (reg_req_eff) begin
        gnt_reg = 1'b1;
      end
    end

    if (!reg_req_eff || gnt_reg) begin
      wait_d = '0;
    end else if (gnt_dst || gnt_src) begin
      wait_d = wait_q + WAIT_W'(1);
    end

    if (gnt_dst || gnt_src) begin
      rr_d = !rr_q;
    end

    if (gnt_dst) begin
      op_d    = OP_DST;
      oq_d    = dst_oq;
      words_d = dst_words;
    end else if (gnt_src) begin
      op_d    = OP_SRC;
      oq_d    = src_oq;
      words_d = src_words;
    end else if (gnt_reg) begin
      op_d     = OP_REG;
      oq_d     = reg_addr[NUM_OQ_WIDTH:1];
      field_d  = reg_addr[0];
      reg_wr_d = reg_wr;
      wdata_d  = reg_wr_data;
    end

    dst_ack_d  = gnt_dst;
    src_ack_d  = gnt_src;
    rf_rd_en_d = gnt_dst || gnt_src || gnt_reg;

    // Modify step: rf_rd_data is valid in MOD
    case (op_q)
      OP_DST: begin
        if (&rd_pkts) sat = 1'b1;
        else          new_pkts = rd_pkts + PKTS_IN_RAM_WIDTH'(1);
        if (words_ext > rd_words) begin
          new_words = '0;
          sat       = 1'b1;
        end else begin
          new_words = rd_words - words_ext;
        end
      end
      OP_SRC: begin
        if (rd_pkts == '0) sat = 1'b1;
        else               new_pkts = rd_pkts - PKTS_IN_RAM_WIDTH'(1);
        if (words_sum[SRAM_ADDR_WIDTH]) begin
          new_words = '1;
          sat       = 1'b1;
        end else begin
          new_words = words_sum[SRAM_ADDR_WIDTH-1:0];
        end
      end
      default: begin
        if (reg_wr_q) begin
          if (field_q) new_words = wdata_q;
          else         new_pkts  = PKTS_IN_RAM_WIDTH'(wdata_q);
        end
      end
    endcase

    case (state_q)
      ST_IDLE: if (rf_rd_en_d) state_d = ST_RD;
      ST_RD:   state_d = ST_MOD;
      ST_MOD: begin
        state_d      = ST_WR;
        rf_wr_en_d   = 1'b1;
        rf_wr_data_d = {new_pkts, new_words};
        err_d        = sat;
        dst_done_d   = (op_q == OP_DST);
        src_done_d   = (op_q == OP_SRC);
        reg_ack_d    = (op_q == OP_REG);
        if ((op_q == OP_REG) && !reg_wr_q) begin
          reg_rd_data_d = field_q ? rd_words : SRAM_ADDR_WIDTH'(rd_pkts);
        end
      end
      default: state_d = rf_rd_en_d ? ST_RD : ST_IDLE;
    endcase
  end

  // State and output registers, synchronous reset aborts any op in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      op_q          <= OP_DST;
      rr_q          <= 1'b0;
      wait_q        <= '0;
      oq_q          <= '0;
      words_q       <= '0;
      reg_wr_q      <= 1'b0;
      field_q       <= 1'b0;
      wdata_q       <= '0;
      dst_ack_q     <= 1'b0;
      src_ack_q     <= 1'b0;
      reg_ack_q     <= 1'b0;
      reg_rd_data_q <= '0;
      rf_rd_en_q    <= 1'b0;
      rf_wr_en_q    <= 1'b0;
      rf_wr_data_q  <= '0;
      dst_done_q    <= 1'b0;
      src_done_q    <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      rr_q          <= rr_d;
      wait_q        <= wait_d;
      oq_q          <= oq_d;
      words_q       <= words_d;
      reg_wr_q      <= reg_wr_d;
      field_q       <= field_d;
      wdata_q       <= wdata_d;
      dst_ack_q     <= dst_ack_d;
      src_ack_q     <= src_ack_d;
      reg_ack_q     <= reg_ack_d;
      reg_rd_data_q <= reg_rd_data_d;
      rf_rd_en_q    <= rf_rd_en_d;
      rf_wr_en_q    <= rf_wr_en_d;
      rf_wr_data_q  <= rf_wr_data_d;
      dst_done_q    <= dst_done_d;
      src_done_q    <= src_done_d;
      err_q         <= err_d;
    end
  end

  assign dst_ack     = dst_ack_q;
  assign src_ack     = src_ack_q;
  assign reg_ack     = reg_ack_q;
  assign reg_rd_data = reg_rd_data_q;
  assign rf_rd_en    = rf_rd_en_q;
  assign rf_addr     = oq_q;
  assign rf_wr_en    = rf_wr_en_q;
  assign rf_wr_data  = rf_wr_data_q;
  assign dst_update  = dst_ack_q;
  assign src_update  = src_ack_q;
  assign dst_done    = dst_done_q;
  assign src_done    = src_done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_oq_regs_update_arb.sv
// Bench for oq_regs_update_arb: register-file model, vector table, scoreboard
// of expected write-backs and hand-written contention / reset sequences.
module tb_oq_regs_update_arb;

  localparam logic [1:0] K_DST = 2'd0;
  localparam logic [1:0] K_SRC = 2'd1;
  localparam logic [1:0] K_REG = 2'd2;

  logic        clk = 1'b0;
  logic        reset;
  logic        dst_req, src_req, reg_req, reg_wr;
  logic [2:0]  dst_oq, src_oq;
  logic [7:0]  dst_words, src_words;
  logic [3:0]  reg_addr;
  logic [18:0] reg_wr_data, reg_rd_data;
  logic        dst_ack, src_ack, reg_ack, rf_rd_en, rf_wr_en;
  logic [2:0]  rf_addr;
  logic [34:0] rf_rd_data, rf_wr_data;
  logic        dst_update, src_update, dst_done, src_done, err;

  logic        pre_en = 1'b0;
  logic [2:0]  pre_idx = 3'd0;
  logic [34:0] pre_val = '0;
  logic [34:0] mem [8];

  typedef struct {
    logic [1:0]  kind;
    logic [2:0]  oq;
    logic [7:0]  words;
    logic        wr;
    logic        field;
    logic [18:0] wdata;
    logic [15:0] ip;
    logic [18:0] iw;
    logic [15:0] ep;
    logic [18:0] ew;
    logic        eerr;
    logic [18:0] erd;
  } vec_t;

  typedef struct {
    logic [1:0]  kind;
    logic        rd;
    logic [34:0] wdata;
    logic        eerr;
    logic [18:0] erd;
  } exp_t;

  exp_t sbq[$];
  int   gq[$];
  vec_t vt[12];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   exp_rr = 1'b0;

  oq_regs_update_arb dut (
    .clk(clk), .reset(reset),
    .dst_req(dst_req), .dst_oq(dst_oq), .dst_words(dst_words), .dst_ack(dst_ack),
    .src_req(src_req), .src_oq(src_oq), .src_words(src_words), .src_ack(src_ack),
    .reg_req(reg_req), .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_wr_data(reg_wr_data),
    .reg_ack(reg_ack), .reg_rd_data(reg_rd_data),
    .rf_rd_en(rf_rd_en), .rf_addr(rf_addr), .rf_rd_data(rf_rd_data),
    .rf_wr_en(rf_wr_en), .rf_wr_data(rf_wr_data),
    .dst_update(dst_update), .src_update(src_update),
    .dst_done(dst_done), .src_done(src_done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register file: one-cycle read latency, bench-side preset port
  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_val;
    else if (rf_wr_en) mem[rf_addr] <= rf_wr_data;
    if (rf_rd_en) rf_rd_data <= mem[rf_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mkv(input logic [1:0] kind, input logic [2:0] oq, input logic [7:0] words,
                               input logic wr, input logic field, input logic [18:0] wdata,
                               input logic [15:0] ip, input logic [18:0] iw,
                               input logic [15:0] ep, input logic [18:0] ew,
                               input logic eerr, input logic [18:0] erd);
    vec_t v;
    v.kind = kind; v.oq = oq; v.words = words; v.wr = wr; v.field = field; v.wdata = wdata;
    v.ip = ip; v.iw = iw; v.ep = ep; v.ew = ew; v.eerr = eerr; v.erd = erd;
    return v;
  endfunction

  task automatic push_exp(input logic [1:0] kind, input logic rd, input logic [15:0] p,
                          input logic [18:0] w, input logic eerr, input logic [18:0] erd);
    exp_t e;
    e.kind = kind; e.rd = rd; e.wdata = {p, w}; e.eerr = eerr; e.erd = erd;
    sbq.push_back(e);
  endtask

  task automatic preset(input logic [2:0] idx, input logic [15:0] p, input logic [18:0] w);
    pre_en = 1'b1; pre_idx = idx; pre_val = {p, w};
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (rf_rd_en) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("grant_timeout", 64'(0), 64'(1));
  endtask

  task automatic idle_inputs();
    dst_req = 1'b0; src_req = 1'b0; reg_req = 1'b0;
    dst_oq = 3'($urandom); dst_words = 8'($urandom);
    src_oq = 3'($urandom); src_words = 8'($urandom);
    reg_wr = 1'($urandom); reg_addr = 4'($urandom); reg_wr_data = 19'($urandom);
  endtask

  // One isolated operation; inputs are scrambled right after the grant
  task automatic do_op(input vec_t v);
    bit ok;
    logic [3:0] flags;
    push_exp(v.kind, (v.kind == K_REG) && !v.wr, v.ep, v.ew, v.eerr, v.erd);
    case (v.kind)
      K_DST: begin dst_req = 1'b1; dst_oq = v.oq; dst_words = v.words; end
      K_SRC: begin src_req = 1'b1; src_oq = v.oq; src_words = v.words; end
      default: begin
        reg_req = 1'b1; reg_wr = v.wr; reg_addr = {v.oq, v.field}; reg_wr_data = v.wdata;
      end
    endcase
    flags = (v.kind == K_DST) ? 4'b1010 : (v.kind == K_SRC) ? 4'b0101 : 4'b0000;
    wait_grant(ok);
    if (ok) begin
      chk("grant_flags", 64'({dst_ack, src_ack, dst_update, src_update}), 64'(flags));
      chk("rf_addr", 64'(rf_addr), 64'(v.oq));
      if (v.kind != K_REG) exp_rr = ~exp_rr;
    end
    if (v.kind == K_REG) begin
      ok = 1'b0;
      for (int n = 0; n < 5; n++) begin
        @(negedge clk);
        if (reg_ack) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) chk("reg_ack_timeout", 64'(0), 64'(1));
    end
    @(posedge clk); #1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    bit ok;
    int who, lastg, cnt_d, cnt_s;
    logic [15:0] dp [2];
    logic [18:0] dw [2];
    logic [15:0] sp [2];
    logic [18:0] sw [2];

    vt[0]  = mkv(K_DST, 3'd3, 8'd64,   1'b0, 1'b0, 19'd0,       16'd5,      19'd1000,    16'd6,      19'd936,     1'b0, 19'd0);
    vt[1]  = mkv(K_SRC, 3'd2, 8'd10,   1'b0, 1'b0, 19'd0,       16'd0,      19'd100,     16'd0,      19'd110,     1'b1, 19'd0);
    vt[2]  = mkv(K_DST, 3'd5, 8'd8,    1'b0, 1'b0, 19'd0,       16'hFFFF,   19'd50,      16'hFFFF,   19'd42,      1'b1, 19'd0);
    vt[3]  = mkv(K_DST, 3'd6, 8'd30,   1'b0, 1'b0, 19'd0,       16'd1,      19'd20,      16'd2,      19'd0,       1'b1, 19'd0);
    vt[4]  = mkv(K_DST, 3'd0, 8'd64,   1'b0, 1'b0, 19'd0,       16'd7,      19'd64,      16'd8,      19'd0,       1'b0, 19'd0);
    vt[5]  = mkv(K_SRC, 3'd1, 8'h20,   1'b0, 1'b0, 19'd0,       16'd3,      19'h7FFF0,   16'd2,      19'h7FFFF,   1'b1, 19'd0);
    vt[6]  = mkv(K_SRC, 3'd7, 8'h0F,   1'b0, 1'b0, 19'd0,       16'd1,      19'h7FFF0,   16'd0,      19'h7FFFF,   1'b0, 19'd0);
    vt[7]  = mkv(K_REG, 3'd4, 8'd0,    1'b1, 1'b0, 19'd2,       16'd9,      19'd500,     16'd2,      19'd500,     1'b0, 19'd0);
    vt[8]  = mkv(K_REG, 3'd4, 8'd0,    1'b1, 1'b1, 19'h12345,   16'd2,      19'd500,     16'd2,      19'h12345,   1'b0, 19'd0);
    vt[9]  = mkv(K_REG, 3'd0, 8'd0,    1'b1, 1'b0, 19'h7ABCD,   16'd1,      19'd2,       16'hABCD,   19'd2,       1'b0, 19'd0);
    vt[10] = mkv(K_REG, 3'd1, 8'd0,    1'b0, 1'b1, 19'd0,       16'd11,     19'd700,     16'd11,     19'd700,     1'b0, 19'd700);
    vt[11] = mkv(K_REG, 3'd3, 8'd0,    1'b0, 1'b0, 19'd0,       16'h1234,   19'd5,       16'h1234,   19'd5,       1'b0, 19'h1234);

    for (int i = 0; i < 8; i++) mem[i] = '0;
    rf_rd_data = '0;
    idle_inputs();
    reset = 1'b1;

    // Write-back monitor: pops the scoreboard on every rf_wr_en
    fork
      forever begin
        automatic exp_t e;
        automatic int g;
        @(negedge clk);
        if (rf_rd_en) gq.push_back(cyc);
        if (rf_wr_en) begin
          if (sbq.size() == 0) begin
            chk("unexpected_write", 64'(rf_wr_data), 64'(0));
          end else begin
            e = sbq.pop_front();
            chk("wr_data", 64'(rf_wr_data), 64'(e.wdata));
            chk("err", 64'(err), 64'(e.eerr));
            chk("done_flags", 64'({dst_done, src_done, reg_ack}),
                64'((e.kind == K_DST) ? 3'b100 : (e.kind == K_SRC) ? 3'b010 : 3'b001));
            if (e.rd) chk("reg_rd_data", 64'(reg_rd_data), 64'(e.erd));
            if (gq.size() > 0) begin
              g = gq.pop_front();
              chk("wr_latency", 64'(cyc - g), 64'(2));
            end
          end
        end else if ({dst_done, src_done, reg_ack, err} != 4'b0) begin
          chk("stray_strobe", 64'({dst_done, src_done, reg_ack, err}), 64'(0));
        end
      end
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_strobes", 64'({dst_ack, src_ack, reg_ack, rf_rd_en, rf_wr_en, dst_update,
                              src_update, dst_done, src_done, err, rf_addr}), 64'(0));
    chk("reset_rf_wr_data", 64'(rf_wr_data), 64'(0));
    chk("reset_reg_rd_data", 64'(reg_rd_data), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Vector table: one isolated op each
    for (int i = 0; i < 12; i++) begin
      preset(vt[i].oq, vt[i].ip, vt[i].iw);
      do_op(vt[i]);
    end

    // Contention: dst and src held, grants alternate 3 cycles apart
    preset(3'd5, 16'd10, 19'd1000);
    preset(3'd6, 16'd10, 19'd0);
    dp[0] = 16'd11; dw[0] = 19'd990; dp[1] = 16'd12; dw[1] = 19'd980;
    sp[0] = 16'd9;  sw[0] = 19'd5;   sp[1] = 16'd8;  sw[1] = 19'd10;
    cnt_d = 0; cnt_s = 0;
    for (int i = 0; i < 4; i++) begin
      if (((i % 2) == 0) ^ exp_rr) push_exp(K_DST, 1'b0, dp[i/2], dw[i/2], 1'b0, 19'd0);
      else                         push_exp(K_SRC, 1'b0, sp[i/2], sw[i/2], 1'b0, 19'd0);
    end
    dst_req = 1'b1; dst_oq = 3'd5; dst_words = 8'd10;
    src_req = 1'b1; src_oq = 3'd6; src_words = 8'd5;
    lastg = 0;
    for (int i = 0; i < 4; i++) begin
      wait_grant(ok);
      if (!ok) break;
      who = dst_ack ? 0 : src_ack ? 1 : 2;
      chk("rr_order", 64'(who), 64'(exp_rr ? 1 : 0));
      if (i > 0) chk("grant_spacing", 64'(cyc - lastg), 64'(3));
      lastg = cyc;
      exp_rr = ~exp_rr;
      if (who == 0) cnt_d++;
      if (who == 1) cnt_s++;
      @(posedge clk); #1;
      if (cnt_d == 2) dst_req = 1'b0;
      if (cnt_s == 2) src_req = 1'b0;
    end
    idle_inputs();
    repeat (4) @(posedge clk);
    #1;

    // Starvation bound: reg wins the 5th grant, then reads q1 words_left
    preset(3'd5, 16'd0, 19'd100);
    preset(3'd6, 16'd5, 19'd50);
    preset(3'd1, 16'd11, 19'd700);
    dp[0] = 16'd1; dw[0] = 19'd99; dp[1] = 16'd2; dw[1] = 19'd98;
    sp[0] = 16'd4; sw[0] = 19'd51; sp[1] = 16'd3; sw[1] = 19'd52;
    for (int i = 0; i < 4; i++) begin
      if (((i % 2) == 0) ^ exp_rr) push_exp(K_DST, 1'b0, dp[i/2], dw[i/2], 1'b0, 19'd0);
      else                         push_exp(K_SRC, 1'b0, sp[i/2], sw[i/2], 1'b0, 19'd0);
    end
    push_exp(K_REG, 1'b1, 16'd11, 19'd700, 1'b0, 19'd700);
    dst_req = 1'b1; dst_oq = 3'd5; dst_words = 8'd1;
    src_req = 1'b1; src_oq = 3'd6; src_words = 8'd1;
    reg_req = 1'b1; reg_wr = 1'b0; reg_addr = {3'd1, 1'b1}; reg_wr_data = 19'h55555;
    for (int i = 0; i < 5; i++) begin
      wait_grant(ok);
      if (!ok) break;
      who = dst_ack ? 0 : src_ack ? 1 : 2;
      chk("starve_order", 64'(who), 64'((i == 4) ? 2 : (exp_rr ? 1 : 0)));
      if (who != 2) exp_rr = ~exp_rr;
      @(posedge clk); #1;
      if (who == 2) begin
        dst_req = 1'b0; src_req = 1'b0;
      end
    end
    ok = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (reg_ack) begin
        ok = 1'b1;
        break;
      end
    end
    chk("starve_reg_ack", 64'(ok), 64'(1));
    @(posedge clk); #1;
    idle_inputs();
    repeat (4) @(posedge clk);
    #1;

    // Reset in MOD of a dst op: no write-back, next op is normal
    preset(3'd3, 16'd5, 19'd1000);
    dst_req = 1'b1; dst_oq = 3'd3; dst_words = 8'd1;
    wait_grant(ok);
    @(posedge clk); #1;
    idle_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    gq.delete();
    exp_rr = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("abort_no_write", 64'({rf_wr_en, dst_done, err}), 64'(0));
    end
    chk("abort_rf_unchanged", 64'(mem[3]), 64'({16'd5, 19'd1000}));
    @(posedge clk); #1;
    do_op(mkv(K_DST, 3'd3, 8'd64, 1'b0, 1'b0, 19'd0, 16'd5, 19'd1000, 16'd6, 19'd936, 1'b0, 19'd0));
    chk("scoreboard_drained", 64'(sbq.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/oq_regs_update_arb.md
Name:
oq_regs_update_arb

Overview:
Sequences every read-modify-write of the per-queue occupancy register file (num_pkts_in_q, num_words_left) for the SRAM round-robin output queues. It arbitrates between store (dst), remove (src) and host register (reg) requesters, one operation at a time. It also generates the update and done strobes consumed by the per-queue full evaluator.

Parameters:
NUM_OUTPUT_QUEUES, 8, number of output queues
NUM_OQ_WIDTH, 3, queue index width
SRAM_ADDR_WIDTH, 19, width of num_words_left field
PKTS_IN_RAM_WIDTH, 16, width of num_pkts_in_q field
PKT_WORDS_WIDTH, 8, width of packet length in words
REG_MAX_WAIT, 4, max dst/src grants taken while reg_req is pending

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
dst_req  in  1  store request; held until dst_ack
dst_oq  in  NUM_OQ_WIDTH  store queue
dst_words  in  PKT_WORDS_WIDTH  words stored
dst_ack  out  1  one-cycle pulse at grant
src_req  in  1  remove request; held until src_ack
src_oq  in  NUM_OQ_WIDTH  remove queue
src_words  in  PKT_WORDS_WIDTH  words freed
src_ack  out  1  one-cycle pulse at grant
reg_req  in  1  host access request; held until reg_ack
reg_wr  in  1  1=write, 0=read
reg_addr  in  NUM_OQ_WIDTH+1  {oq, field}; field 0=num_pkts, 1=words_left
reg_wr_data  in  SRAM_ADDR_WIDTH  write value, zero-extended/truncated to field width
reg_ack  out  1  one-cycle pulse at completion (G+2)
reg_rd_data  out  SRAM_ADDR_WIDTH  read value, valid with reg_ack, zero-extended
rf_rd_en  out  1  register file read strobe; data returns next cycle
rf_addr  out  NUM_OQ_WIDTH  queue index, stable G..G+2
rf_rd_data  in  PKTS_IN_RAM_WIDTH+SRAM_ADDR_WIDTH  {num_pkts, words_left}
rf_wr_en  out  1  write strobe
rf_wr_data  out  PKTS_IN_RAM_WIDTH+SRAM_ADDR_WIDTH  {num_pkts, words_left}, valid with rf_wr_en
dst_update  out  1  pulse at grant of a dst op
src_update  out  1  pulse at grant of a src op
dst_done  out  1  pulse with rf_wr_en for a dst op
src_done  out  1  pulse with rf_wr_en for a src op
err  out  1  pulse with rf_wr_en when the arithmetic saturated

Behaviour:
- Reset: all outputs 0, FSM=IDLE, wait counter 0, dst/src RR pointer=dst. Reset mid-op aborts the op: no rf_wr_en, done or ack follows.
- FSM: IDLE -> RD (grant cycle G: rf_rd_en=1, ack for dst/src, dst_update or src_update) -> MOD (G+1: capture rf_rd_data, compute) -> WR (G+2: rf_wr_en, done/reg_ack) -> IDLE. Next grant no earlier than G+3.
- Requester inputs are sampled at G and held internally, so they may change after the ack.
- Arbitration in IDLE:
  - If reg_req=1 and wait counter = REG_MAX_WAIT, reg wins.
  - Else if dst_req and src_req are both set, alternate using the RR pointer; the pointer flips after each dst/src grant.
  - Else a single dst or src requester wins.
  - Else reg wins.
- Wait counter: increments on each dst/src grant while reg_req=1; clears on reg grant or when reg_req=0.
- dst op:
  - num_pkts+1, saturating at all-ones (err).
  - words_left-dst_words; if dst_words > words_left, result 0 (err).
- src op:
  - If num_pkts=0: num_pkts stays 0 (err); words_left is still updated.
  - Else num_pkts-1.
  - words_left+src_words, saturating at all-ones (err).
- reg read: rf_wr_en is still asserted, writing back the unchanged data. reg_rd_data is the selected field.
- reg write: replaces the selected field; the other field is preserved.
- dst_update/src_update pulse at G, so the full evaluator latches its thresholds at G+1. dst_done/src_done at G+2 coincide with rf_wr_data.

Test Plan:
- Store: q3 = {5, 1000}; dst_req oq=3 words=64 -> dst_ack and dst_update at G; rf_rd_en at G; rf_wr_en and dst_done at G+2 with {6, 936}; err=0.
- Remove from empty queue: q2 = {0, 100}; src words=10 -> rf_wr_data {0, 110}; err=1.
- Contention: dst and src held continuously -> grants alternate dst, src, dst, src; grants are 3 cycles apart.
- Starvation bound: reg_req held while dst/src are saturated -> reg granted on the 5th grant (after 4 dst/src grants). reg read of q1 field 1 returns 700 on reg_ack at G+2.
- Reg write: q4 = {9, 500}; write field 0 = 2 -> {2, 500}; no dst_done or src_done.
- Reset asserted in MOD of a dst op -> no rf_wr_en or dst_done; FSM returns to IDLE; the next request gets a normal 3-cycle op.
